// File: rtl/scoring_engine.sv
// ---------------------------------------------------------------------------
// scoring_engine
//
// Game-state and scoring block for the Pacman datapath. It keeps a
// tile-granular pellet map and power-pellet map, awards points for pellets,
// power pellets and eaten ghosts, tracks lives and frightened mode, and
// decides win/lose. The renderer reads the maps through a combinational
// query port.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   start               leave IDLE and begin a game
//   ack                 acknowledge WIN/LOSE and return to IDLE
//   tile_valid          one-cycle pulse: pacman entered (pac_tx, pac_ty)
//   pac_tx, pac_ty      pacman tile coordinates
//   ghost_hit           per-ghost overlap level
//   rd_tx, rd_ty        renderer query tile
//   rd_pellet, rd_power combinational map contents at the query tile
//   score               saturating score
//   lives               remaining lives
//   pellets_left        pellets plus power pellets still on the map
//   frightened          frightened mode active
//   ghost_eaten         one-hot, one-cycle pulse per eaten ghost
//   win, lose           game outcome, held until ack
// ---------------------------------------------------------------------------
module scoring_engine #(
  parameter int GRID_W        = 28,
  parameter int GRID_H        = 31,
  parameter int NUM_GHOSTS    = 4,
  parameter int SCORE_W       = 16,
  parameter int LIVES         = 3,
  parameter int PELLET_PTS    = 10,
  parameter int POWER_PTS     = 50,
  parameter int GHOST_PTS     = 200,
  parameter int FRIGHT_CYCLES = 2000,
  parameter int DEATH_CYCLES  = 120,
  parameter logic [GRID_W*GRID_H-1:0] PELLET_INIT = '1,
  parameter logic [GRID_W*GRID_H-1:0] POWER_INIT  = '0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic                      ack,
  input  logic                      tile_valid,
  input  logic [$clog2(GRID_W)-1:0] pac_tx,
  input  logic [$clog2(GRID_H)-1:0] pac_ty,
  input  logic [NUM_GHOSTS-1:0]     ghost_hit,
  input  logic [$clog2(GRID_W)-1:0] rd_tx,
  input  logic [$clog2(GRID_H)-1:0] rd_ty,
  output logic                      rd_pellet,
  output logic                      rd_power,
  output logic [SCORE_W-1:0]        score,
  output logic [2:0]                lives,
  output logic [15:0]               pellets_left,
  output logic                      frightened,
  output logic [NUM_GHOSTS-1:0]     ghost_eaten,
  output logic                      win,
  output logic                      lose
);

  localparam int N  = GRID_W * GRID_H;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int FW = $clog2(FRIGHT_CYCLES + 1);
  localparam int DW = (DEATH_CYCLES > 1) ? $clog2(DEATH_CYCLES) : 1;
  localparam logic [SCORE_W-1:0] SCORE_SAT = {SCORE_W{1'b1}};

  function automatic logic [15:0] count_ones(input logic [N-1:0] v);
    logic [15:0] c;
    c = '0;
    for (int i = 0; i < N; i++) begin
      c = c + 16'(v[i]);
    end
    return c;
  endfunction

  localparam logic [15:0] INIT_LEFT = count_ones(PELLET_INIT | POWER_INIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PLAY,
    S_DEATH,
    S_WIN,
    S_LOSE
  } state_t;

  state_t                  state;
  logic [N-1:0]            pellet_map;
  logic [N-1:0]            power_map;
  logic [FW-1:0]           fright_cnt;
  logic [1:0]              combo;
  logic [NUM_GHOSTS-1:0]   ghost_done;
  logic [DW-1:0]           death_cnt;

  logic                    pac_ok;
  logic [IW-1:0]           pac_idx;
  logic                    rd_ok;
  logic [IW-1:0]           rd_idx;
  logic                    eat_pellet;
  logic                    eat_power;
  logic [N-1:0]            pellet_map_next;
  logic [N-1:0]            power_map_next;
  logic [15:0]             left_next;
  logic                    win_now;
  logic [FW-1:0]           fright_next;
  logic [1:0]              combo_base;
  logic [1:0]              combo_next;
  logic [NUM_GHOSTS-1:0]   ghost_cand;
  logic [NUM_GHOSTS-1:0]   ghost_sel;
  logic [NUM_GHOSTS-1:0]   done_next;
  logic                    eat_ghost;
  logic                    lethal;
  logic [33:0]             pts_tile;
  logic [33:0]             pts_ghost;
  logic [33:0]             score_sum;
  logic [SCORE_W-1:0]      score_next;

  // Coordinates past the maze edge never touch the maps.
  assign pac_ok  = (int'(pac_tx) < GRID_W) && (int'(pac_ty) < GRID_H);
  assign pac_idx = IW'(int'(pac_ty) * GRID_W + int'(pac_tx));
  assign rd_ok   = (int'(rd_tx) < GRID_W) && (int'(rd_ty) < GRID_H);
  assign rd_idx  = IW'(int'(rd_ty) * GRID_W + int'(rd_tx));

  assign rd_pellet = rd_ok && pellet_map[rd_idx];
  assign rd_power  = rd_ok && power_map[rd_idx];

  assign eat_pellet = tile_valid && pac_ok && pellet_map[pac_idx];
  assign eat_power  = tile_valid && pac_ok && !pellet_map[pac_idx] && power_map[pac_idx];

  // One PLAY cycle: the tile update goes first, then ghost collisions are
  // judged against the frightened flag as it stood before this cycle.
  // A ghost already eaten during the current fright period is treated as
  // gone, so a ghost_hit that stays asserted does not score it again.
  always_comb begin
    pellet_map_next = pellet_map;
    power_map_next  = power_map;
    if (eat_pellet) pellet_map_next[pac_idx] = 1'b0;
    if (eat_power)  power_map_next[pac_idx]  = 1'b0;

    left_next = pellets_left - 16'(eat_pellet | eat_power);
    win_now   = (left_next == 16'd0);

    if (eat_power)              fright_next = FW'(FRIGHT_CYCLES);
    else if (fright_cnt != '0)  fright_next = fright_cnt - FW'(1);
    else                        fright_next = '0;

    combo_base = eat_power ? 2'd0 : combo;

    // x & -x isolates the lowest set bit: lowest-index ghost wins.
    ghost_cand = ghost_hit & ~ghost_done;
    ghost_sel  = ghost_cand & (~ghost_cand + NUM_GHOSTS'(1));
    eat_ghost  = frightened && (ghost_cand != '0) && !win_now;
    lethal     = !frightened && (ghost_hit != '0) && !win_now;

    if (eat_ghost) combo_next = (combo_base == 2'd3) ? 2'd3 : combo_base + 2'd1;
    else           combo_next = combo_base;

    done_next = (eat_power || !frightened) ? '0 : ghost_done;
    if (eat_ghost) done_next = done_next | ghost_sel;

    if (eat_pellet)     pts_tile = 34'(PELLET_PTS);
    else if (eat_power) pts_tile = 34'(POWER_PTS);
    else                pts_tile = '0;
    pts_ghost = eat_ghost ? (34'(GHOST_PTS) << combo_base) : '0;

    // Single saturation of the whole sum equals saturating each step,
    // because every award is non-negative.
    score_sum  = 34'(score) + pts_tile + pts_ghost;
    score_next = (score_sum > 34'(SCORE_SAT)) ? SCORE_SAT : score_sum[SCORE_W-1:0];
  end

  // Game FSM with registered outputs. IDLE keeps reloading the start-of-game
  // values so the renderer shows a fresh maze; leaving WIN/LOSE on ack does
  // the same reload so IDLE values appear on the very next cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      pellet_map   <= PELLET_INIT;
      power_map    <= POWER_INIT;
      score        <= '0;
      lives        <= 3'(LIVES);
      pellets_left <= INIT_LEFT;
      fright_cnt   <= '0;
      frightened   <= 1'b0;
      combo        <= '0;
      ghost_done   <= '0;
      ghost_eaten  <= '0;
      death_cnt    <= '0;
      win          <= 1'b0;
      lose         <= 1'b0;
    end else begin
      ghost_eaten <= '0;
      case (state)
        S_IDLE: begin
          pellet_map   <= PELLET_INIT;
          power_map    <= POWER_INIT;
          score        <= '0;
          lives        <= 3'(LIVES);
          pellets_left <= INIT_LEFT;
          fright_cnt   <= '0;
          frightened   <= 1'b0;
          combo        <= '0;
          ghost_done   <= '0;
          if (start) state <= S_PLAY;
        end

        S_PLAY: begin
          pellet_map   <= pellet_map_next;
          power_map    <= power_map_next;
          pellets_left <= left_next;
          score        <= score_next;
          fright_cnt   <= fright_next;
          frightened   <= (fright_next != '0);
          combo        <= combo_next;
          ghost_done   <= done_next;
          if (win_now) begin
            state <= S_WIN;
            win   <= 1'b1;
          end else if (eat_ghost) begin
            ghost_eaten <= ghost_sel;
          end else if (lethal) begin
            lives      <= lives - 3'd1;
            fright_cnt <= '0;
            frightened <= 1'b0;
            combo      <= '0;
            ghost_done <= '0;
            if (lives <= 3'd1) begin
              state <= S_LOSE;
              lose  <= 1'b1;
            end else begin
              state     <= S_DEATH;
              death_cnt <= DW'(DEATH_CYCLES - 1);
            end
          end
        end

        // Pause for DEATH_CYCLES cycles; everything else is frozen.
        S_DEATH: begin
          if (death_cnt == '0) state <= S_PLAY;
          else                 death_cnt <= death_cnt - DW'(1);
        end

        S_WIN, S_LOSE: begin
          if (ack) begin
            state        <= S_IDLE;
            win          <= 1'b0;
            lose         <= 1'b0;
            pellet_map   <= PELLET_INIT;
            power_map    <= POWER_INIT;
            score        <= '0;
            lives        <= 3'(LIVES);
            pellets_left <= INIT_LEFT;
            fright_cnt   <= '0;
            frightened   <= 1'b0;
            combo        <= '0;
            ghost_done   <= '0;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/scoring_engine.md
Name: scoring_engine

Overview:
- Parametrised next-generation scoring and game-state block for the Pacman datapath.
- Owns a tile-granular pellet/power-pellet map internally, so there are no full-screen pixel arrays.
- Tracks score, lives, frightened mode and per-ghost eat events, and drives win/lose.
- Sits between the pacman/ghost movement modules (tile events, collisions) and the VGA renderer (map read port, status).

Parameters:
GRID_W, 28, maze width in tiles
GRID_H, 31, maze height in tiles
NUM_GHOSTS, 4, number of ghost collision inputs
SCORE_W, 16, score width
LIVES, 3, lives at game start (1..7)
PELLET_PTS, 10, points per pellet
POWER_PTS, 50, points per power pellet
GHOST_PTS, 200, base points per eaten ghost; doubles per combo step
FRIGHT_CYCLES, 2000, frightened duration in clk cycles after a power pellet
DEATH_CYCLES, 120, pause length after losing a life
PELLET_INIT, all-ones GRID_W*GRID_H bits, initial pellet map, bit index = ty*GRID_W+tx
POWER_INIT, 0, initial power-pellet map, same indexing; must not overlap PELLET_INIT

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start  in  1  begin game from IDLE
ack  in  1  acknowledge end of game (WIN/LOSE -> IDLE)
tile_valid  in  1  one-cycle pulse: pacman entered tile (pac_tx, pac_ty)
pac_tx  in  $clog2(GRID_W)  pacman tile x
pac_ty  in  $clog2(GRID_H)  pacman tile y
ghost_hit  in  NUM_GHOSTS  level: ghost i overlaps pacman this cycle
rd_tx  in  $clog2(GRID_W)  renderer query tile x
rd_ty  in  $clog2(GRID_H)  renderer query tile y
rd_pellet  out  1  combinational: pellet present at rd tile
rd_power  out  1  combinational: power pellet present at rd tile
score  out  SCORE_W  current score
lives  out  3  remaining lives
pellets_left  out  16  pellets plus power pellets remaining
frightened  out  1  frightened mode active
ghost_eaten  out  NUM_GHOSTS  one-hot one-cycle pulse: ghost i eaten
win  out  1  state == WIN
lose  out  1  state == LOSE

Behaviour:
- States: IDLE, PLAY, DEATH, WIN, LOSE. All outputs are registered except rd_pellet and rd_power.
- Reset (reset_n low, any time, including mid-game):
  - state = IDLE; score = 0; lives = LIVES.
  - Maps = PELLET_INIT / POWER_INIT; pellets_left = popcount of both maps.
  - Fright counter and combo = 0; ghost_eaten = 0.
- IDLE:
  - Each cycle reloads maps, score = 0, lives = LIVES, pellets_left, and clears fright.
  - start -> PLAY next cycle.
  - Inputs other than start are ignored.
- PLAY, pellet/tile rules:
  - tile_valid with pellet at tile: clear bit, score += PELLET_PTS, pellets_left -= 1.
  - tile_valid with power pellet at tile: clear bit, score += POWER_PTS, pellets_left -= 1, fright counter = FRIGHT_CYCLES, combo = 0.
  - A power pellet eaten while already frightened reloads the counter and resets combo.
  - tile_valid on an empty tile or an out-of-range coordinate: no effect.
- PLAY, fright counter:
  - Decrements by 1 per PLAY cycle while nonzero.
  - frightened = (counter != 0).
- PLAY, ghost collision while frightened:
  - Only the lowest-index asserted ghost_hit bit is serviced per cycle.
  - ghost_eaten[i] pulses; score += GHOST_PTS << combo; combo saturates at 3.
  - Other asserted bits are serviced on later cycles if still asserted.
- PLAY, ghost collision while not frightened (any bit):
  - lives -= 1.
  - lives reaching 0 -> LOSE; otherwise -> DEATH.
- Same-cycle precedence in PLAY:
  - Pellet update is applied first.
  - If pellets_left becomes 0 -> WIN, overriding any same-cycle lethal hit.
  - Otherwise collision evaluation uses the frightened value from before this cycle; a power pellet and a lethal hit in the same cycle is a death.
- Score arithmetic: all additions saturate at 2^SCORE_W-1; no wrap.
- DEATH:
  - Counts DEATH_CYCLES, then -> PLAY.
  - Maps, score and pellets_left are preserved; fright and combo are cleared.
  - tile_valid and ghost_hit are ignored.
- WIN / LOSE:
  - Hold all values.
  - ack -> IDLE. start is ignored.
- Renderer read port: reflects the map including the clear performed on the previous edge; no read latency.

Test Plan:
- Reset, start, tile_valid on 3 pellet tiles -> score 30, pellets_left = initial-3, rd_pellet 0 at those tiles; repeat a tile -> score unchanged.
- Eat power pellet, then ghost_hit = 4'b0101 held for 4 cycles -> ghost_eaten 0001 then 0100; score += 50+200+400; frightened drops exactly FRIGHT_CYCLES PLAY cycles after the power pellet.
- Unfrightened ghost_hit with LIVES=3 -> lives 2, DEATH for DEATH_CYCLES, back to PLAY with map intact; third death -> lose=1; ack -> IDLE, score 0, lives 3.
- Last pellet eaten in same cycle as lethal ghost_hit -> WIN, lives unchanged; power pellet + lethal hit in same cycle -> DEATH.
- Score preloaded near saturation (SCORE_W=8): ghost eat -> score 255, no wrap.
- reset_n asserted mid-frightened PLAY -> immediate IDLE, frightened 0, maps restored to PELLET_INIT/POWER_INIT.
